alu_seq: RTL and testbench

- Parametrised, registered successor to the datapath's combinational ALU.
- Supports the same eight base operations plus XOR, iterative shifts and an iterative shift-add multiply.
- Produces Z/N/C/V status flags for the control unit's branch logic.
- Operands are latched on a start handshake. Single-cycle ops complete in 1 cycle; shift and multiply ops run multi-cycle with busy/done signalling.

---
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with iterative shifts and shift-add multiply; Z/N/C/V flags update only on done.
// Latency: 1 cycle for single-cycle ops, max(n,1) for shifts, WIDTH for MUL.
// Backpressure: while busy is high, start is ignored. Nothing is queued.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD     = 4'd0;
   localparam logic [3:0] OP_AND     = 4'd1;
   localparam logic [3:0] OP_INC_Y   = 4'd2;
   localparam logic [3:0] OP_NOT_A   = 4'd3;
   localparam logic [3:0] OP_OR      = 4'd4;
   localparam logic [3:0] OP_PASS_Y  = 4'd5;
   localparam logic [3:0] OP_SUB     = 4'd6;
   localparam logic [3:0] OP_ADD_DEC = 4'd7;
   localparam logic [3:0] OP_XOR     = 4'd8;
   localparam logic [3:0] OP_SHL     = 4'd9;
   localparam logic [3:0] OP_SHR     = 4'd10;
   localparam logic [3:0] OP_MUL     = 4'd11;

   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SHW-1:0]   CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nx;
   logic [3:0]         op_q, op_nx;
   logic [WIDTH-1:0]   opa_q, opa_nx;
   logic [2*WIDTH-1:0] work_q, work_nx;
   logic [SHW-1:0]     cnt_q, cnt_nx;
   logic               done_nx, z_nx, n_nx, c_nx, v_nx;
   logic [WIDTH-1:0]   res_nx;
   logic               fin, fin_c, fin_v;
   logic [WIDTH-1:0]   fin_res;

   logic [WIDTH:0]     sum_add, diff;
   logic [SHW-1:0]     sh_amt;
   logic [WIDTH-1:0]   sh;
   logic [2*WIDTH-1:0] mul_first, mul_nx;

   // One shift-add step on {hi, multiplier}: add multiplicand to hi when the
   // current multiplier LSB is set, then shift the whole product right by one.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0] m);
      logic [WIDTH:0] sum;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
      return {sum, p[WIDTH-1:1]};
   endfunction

   assign sum_add   = {1'b0, a} + {1'b0, y};
   assign diff      = {1'b0, a} - {1'b0, y};
   assign sh_amt    = y[SHW-1:0];
   assign sh        = work_q[WIDTH-1:0];
   assign mul_first = mul_step({{WIDTH{1'b0}}, y}, a);
   assign mul_nx    = mul_step(work_q, opa_q);
   assign busy      = (state == RUN);

   always_comb begin
      state_nx = state;
      op_nx    = op_q;
      opa_nx   = opa_q;
      work_nx  = work_q;
      cnt_nx   = cnt_q;
      done_nx  = 1'b0;
      res_nx   = result;
      z_nx     = flag_z;
      n_nx     = flag_n;
      c_nx     = flag_c;
      v_nx     = flag_v;
      fin      = 1'b0;
      fin_res  = '0;
      fin_c    = 1'b0;
      fin_v    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               fin = 1'b1;
               case (op)
                  OP_ADD: begin
                     fin_res = sum_add[WIDTH-1:0];
                     fin_c   = sum_add[WIDTH];
                     fin_v   = (a[WIDTH-1] == y[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_AND:     fin_res = a & y;
                  OP_INC_Y: begin
                     fin_res = y + ONE;
                     fin_c   = &y;
                  end
                  OP_NOT_A:   fin_res = ~a;
                  OP_OR:      fin_res = a | y;
                  OP_PASS_Y:  fin_res = y;
                  OP_SUB: begin
                     fin_res = diff[WIDTH-1:0];
                     fin_c   = diff[WIDTH];
                     fin_v   = (a[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_ADD_DEC: fin_res = a + y + {WIDTH{1'b1}};
                  OP_XOR:     fin_res = a ^ y;
                  OP_SHL, OP_SHR: begin
                     // The first shift happens on the start edge, so n<=1 never enters RUN.
                     if (sh_amt == '0) begin
                        fin_res = a;
                     end else if (sh_amt == CNT_ONE) begin
                        fin_res = (op == OP_SHL) ? {a[WIDTH-2:0], 1'b0} : {1'b0, a[WIDTH-1:1]};
                        fin_c   = (op == OP_SHL) ? a[WIDTH-1] : a[0];
                     end else begin
                        fin      = 1'b0;
                        state_nx = RUN;
                        op_nx    = op;
                        cnt_nx   = sh_amt - CNT_ONE;
                        work_nx  = (op == OP_SHL) ? {{WIDTH{1'b0}}, a[WIDTH-2:0], 1'b0}
                                                  : {{WIDTH{1'b0}}, 1'b0, a[WIDTH-1:1]};
                     end
                  end
                  OP_MUL: begin
                     fin      = 1'b0;
                     state_nx = RUN;
                     op_nx    = op;
                     opa_nx   = a;
                     cnt_nx   = {SHW{1'b1}};
                     work_nx  = mul_first;
                  end
                  default:    fin_res = '0;
               endcase
            end
         end
         RUN: begin
            cnt_nx = cnt_q - CNT_ONE;
            if (op_q == OP_MUL) begin
               work_nx = mul_nx;
               fin_res = mul_nx[WIDTH-1:0];
               fin_c   = |mul_nx[2*WIDTH-1:WIDTH];
            end else if (op_q == OP_SHL) begin
               fin_res = {sh[WIDTH-2:0], 1'b0};
               fin_c   = sh[WIDTH-1];
               work_nx = {{WIDTH{1'b0}}, sh[WIDTH-2:0], 1'b0};
            end else begin
               fin_res = {1'b0, sh[WIDTH-1:1]};
               fin_c   = sh[0];
               work_nx = {{WIDTH{1'b0}}, 1'b0, sh[WIDTH-1:1]};
            end
            if (cnt_q == CNT_ONE) begin
               fin      = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (fin) begin
         done_nx = 1'b1;
         res_nx  = fin_res;
         z_nx    = (fin_res == '0);
         n_nx    = fin_res[WIDTH-1];
         c_nx    = fin_c;
         v_nx    = fin_v;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_q   <= '0;
         opa_q  <= '0;
         work_q <= '0;
         cnt_q  <= '0;
         done   <= 1'b0;
         result <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else begin
         state  <= state_nx;
         op_q   <= op_nx;
         opa_q  <= opa_nx;
         work_q <= work_nx;
         cnt_q  <= cnt_nx;
         done   <= done_nx;
         result <= res_nx;
         flag_z <= z_nx;
         flag_n <= n_nx;
         flag_c <= c_nx;
         flag_v <= v_nx;
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=16); expected values are hand-computed.
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [15:0] a = 16'd0;
   logic [15:0] y = 16'd0;
   logic        busy, done;
   logic [15:0] result;
   logic        flag_z, flag_n, flag_c, flag_v;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .y      (y),
      .busy   (busy),
      .done   (done),
      .result (result),
      .flag_z (flag_z),
      .flag_n (flag_n),
      .flag_c (flag_c),
      .flag_v (flag_v)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op, wait for done, then check latency, busy count, result and {Z,N,C,V}.
   // With disturb set, a conflicting ADD start and new operands are driven mid-operation.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] aa,
                         input logic [15:0] yy, input int lat, input logic [15:0] exp_res,
                         input logic [3:0] exp_flags, input bit disturb);
      int cycles;
      int busy_cnt;
      @(negedge clk);
      start = 1'b1; op = o; a = aa; y = yy;
      @(posedge clk); #1;
      start = 1'b0; op = 4'hf; a = 16'h5a5a; y = 16'ha5a5;
      cycles = 1;
      busy_cnt = 0;
      while (!done && cycles < 64) begin
         if (busy) busy_cnt++;
         if (disturb && cycles == 3) begin
            start = 1'b1; op = 4'd0; a = 16'hffff; y = 16'h0001;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
      check({tag, ".done"}, done, 1);
      check({tag, ".latency"}, cycles, lat);
      check({tag, ".busy_cycles"}, busy_cnt, lat - 1);
      check({tag, ".busy_at_done"}, busy, 0);
      check({tag, ".result"}, result, exp_res);
      check({tag, ".flags_zncv"}, {flag_z, flag_n, flag_c, flag_v}, exp_flags);
      if (disturb) begin
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({tag, ".no_extra_done"}, done, 0);
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.result", result, 16'h0000);
      check("reset.flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      //        tag        op     a         y         L   result    ZNCV
      run_op("add_wrap",  4'd0,  16'hffff, 16'h0001, 1,  16'h0000, 4'b1010, 0);
      run_op("add_ovf",   4'd0,  16'h7fff, 16'h0001, 1,  16'h8000, 4'b0101, 0);
      run_op("sub_ovf",   4'd6,  16'h8000, 16'h0001, 1,  16'h7fff, 4'b0001, 0);
      run_op("sub_borrow",4'd6,  16'h0003, 16'h0005, 1,  16'hfffe, 4'b0110, 0);
      run_op("add_dec",   4'd7,  16'h0010, 16'h0005, 1,  16'h0014, 4'b0000, 0);
      run_op("inc_y",     4'd2,  16'h1234, 16'hffff, 1,  16'h0000, 4'b1010, 0);
      run_op("not_a",     4'd3,  16'h00ff, 16'h0000, 1,  16'hff00, 4'b0100, 0);
      run_op("and",       4'd1,  16'hf0f0, 16'hff00, 1,  16'hf000, 4'b0100, 0);
      run_op("or",        4'd4,  16'h0f00, 16'h00f0, 1,  16'h0ff0, 4'b0000, 0);
      run_op("pass_y",    4'd5,  16'h0000, 16'h8000, 1,  16'h8000, 4'b0100, 0);
      run_op("xor",       4'd8,  16'haaaa, 16'haaaa, 1,  16'h0000, 4'b1000, 0);
      run_op("illegal",   4'hf,  16'h1234, 16'h5678, 1,  16'h0000, 4'b1000, 0);
      run_op("mul",       4'd11, 16'h0102, 16'h0003, 16, 16'h0306, 4'b0000, 0);
      // Back-to-back: this start lands in the MUL done cycle.
      run_op("mul_ovf",   4'd11, 16'h1000, 16'h0010, 16, 16'h0000, 4'b1010, 0);
      run_op("shl_n1",    4'd9,  16'h8001, 16'h0011, 1,  16'h0002, 4'b0010, 0);
      run_op("shr_n4",    4'd10, 16'h00f0, 16'h0004, 4,  16'h000f, 4'b0000, 0);
      run_op("shl_n0",    4'd9,  16'h1234, 16'h0010, 1,  16'h1234, 4'b0000, 0);
      run_op("shl_n15",   4'd9,  16'h0001, 16'h000f, 15, 16'h8000, 4'b0100, 0);
      run_op("shr_n2",    4'd10, 16'h8003, 16'h0002, 2,  16'h2000, 4'b0010, 0);
      run_op("mul_dist",  4'd11, 16'h00ff, 16'h0101, 16, 16'hffff, 4'b0100, 1);
      run_op("after_dist",4'd0,  16'h0001, 16'h0002, 1,  16'h0003, 4'b0000, 0);

      // Reset in the middle of a multiply.
      run_op("pre_rst",   4'd6,  16'h0003, 16'h0005, 1,  16'hfffe, 4'b0110, 0);
      @(negedge clk);
      start = 1'b1; op = 4'd11; a = 16'h0102; y = 16'h0003;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("mid_mul.busy", busy, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid.busy", busy, 0);
      check("rst_mid.done", done, 0);
      check("rst_mid.result", result, 16'h0000);
      check("rst_mid.flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst",  4'd0,  16'h1234, 16'h1111, 1,  16'h2345, 4'b0000, 0);
      repeat (20) begin
         @(posedge clk); #1;
         check("post_rst.idle_done", done, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
